// File: rtl/ISO14443A_pkg.sv
// -----------------------------------------------------------------------------
// ISO14443A_pkg
// Shared types and constants for the ISO/IEC 14443 type A receive path.
//   PCDBitSequence   : decoded modified-Miller sequence of one bit period
//   decoder_state_t  : state of the PCD sequence decoder
//   BIT_TICKS        : carrier clocks per bit period (fc/128)
//   within_tol()     : window test used to classify pause timing
// -----------------------------------------------------------------------------
package ISO14443A_pkg;

    localparam int BIT_TICKS = 128;

    typedef enum logic [1:0] {
        PCDBitSequence_X     = 2'd0,
        PCDBitSequence_Y     = 2'd1,
        PCDBitSequence_Z     = 2'd2,
        PCDBitSequence_ERROR = 2'd3
    } PCDBitSequence;

    // LAST_Z / LAST_X remember which kind of pause started the current
    // timing reference; ERR_WAIT swallows traffic after a decode error.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAST_Z   = 2'd1,
        ST_LAST_X   = 2'd2,
        ST_ERR_WAIT = 2'd3
    } decoder_state_t;

    // True when cnt lies inside nominal +/- tol (inclusive).
    function automatic logic within_tol(input int cnt, input int nominal, input int tol);
        return (cnt >= nominal - tol) && (cnt <= nominal + tol);
    endfunction

endpackage

// File: rtl/pcd_seq_decoder.sv
// -----------------------------------------------------------------------------
// pcd_seq_decoder
// Decodes modified-Miller PCD->PICC frames into one sequence (X, Y, Z or
// ERROR) per bit period. Only pause falling edges are timed, so decoding does
// not depend on pause length. The timing reference is the last pause edge;
// Y bits are inferred when no edge arrives before the X window closes.
//
// Ports
//   clk                   in   carrier clock (13.56 MHz), one bit = BIT_TICKS
//   rst_n                 in   synchronous active-low reset
//   pause_n_synchronised  in   PCD pause, active low, synchronised to clk
//   seq                   out  last decoded sequence, held between pulses
//   seq_valid             out  one-cycle pulse when seq updates
//   idle                  out  high while no frame is in progress
// -----------------------------------------------------------------------------
module pcd_seq_decoder
    import ISO14443A_pkg::*;
#(
    parameter int BIT_TICKS = ISO14443A_pkg::BIT_TICKS,
    parameter int TOL       = 16,
    parameter int CNT_W     = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pause_n_synchronised,
    output PCDBitSequence seq,
    output logic          seq_valid,
    output logic          idle
);

    localparam int              HALF_TICKS = BIT_TICKS / 2;
    localparam int              ERR_TICKS  = 2 * BIT_TICKS;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic            prev_pause_n;
    logic [CNT_W-1:0] cnt;
    decoder_state_t  state, state_n;
    logic            k, k_n;          // Y bits emitted since the last edge
    logic            emit;
    PCDBitSequence   emit_seq;

    logic pause_edge;
    int   cnt_i;
    int   bit_start;                  // nominal Z edge time
    int   y_deadline;                 // first count past the X window

    assign pause_edge = prev_pause_n & ~pause_n_synchronised;
    assign cnt_i      = int'(cnt);
    assign bit_start  = ((state == ST_LAST_X) ? HALF_TICKS : BIT_TICKS)
                        + (k ? BIT_TICKS : 0);
    assign y_deadline = bit_start + HALF_TICKS + TOL + 1;

    // -------------------------------------------------------------------------
    // Next-state / emission logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_n  = state;
        k_n      = k;
        emit     = 1'b0;
        emit_seq = PCDBitSequence_Y;

        case (state)
            ST_IDLE: begin
                if (pause_edge) begin
                    emit     = 1'b1;
                    emit_seq = PCDBitSequence_Z;   // start of communication
                    state_n  = ST_LAST_Z;
                    k_n      = 1'b0;
                end
            end

            ST_LAST_Z, ST_LAST_X: begin
                if (pause_edge) begin
                    emit = 1'b1;
                    k_n  = 1'b0;
                    if (within_tol(cnt_i, bit_start, TOL)) begin
                        // A Z directly after an X is not a legal sequence.
                        if (state == ST_LAST_X && !k) begin
                            emit_seq = PCDBitSequence_ERROR;
                            state_n  = ST_ERR_WAIT;
                        end else begin
                            emit_seq = PCDBitSequence_Z;
                            state_n  = ST_LAST_Z;
                        end
                    end else if (within_tol(cnt_i, bit_start + HALF_TICKS, TOL)) begin
                        emit_seq = PCDBitSequence_X;
                        state_n  = ST_LAST_X;
                    end else begin
                        emit_seq = PCDBitSequence_ERROR;
                        state_n  = ST_ERR_WAIT;
                    end
                end else if (cnt_i == y_deadline) begin
                    emit     = 1'b1;
                    emit_seq = PCDBitSequence_Y;
                    if (k) begin
                        // Second Y in a row: end of communication.
                        state_n = ST_IDLE;
                        k_n     = 1'b0;
                    end else begin
                        k_n = 1'b1;
                    end
                end
            end

            ST_ERR_WAIT: begin
                // Edges restart the counter, so this waits for a quiet gap.
                if (!pause_edge && cnt_i >= ERR_TICKS) begin
                    state_n = ST_IDLE;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers: edge detect, interval counter, FSM, registered outputs
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_pause_n <= 1'b1;
            cnt          <= '0;
            state        <= ST_IDLE;
            k            <= 1'b0;
            seq          <= PCDBitSequence_Y;
            seq_valid    <= 1'b0;
            idle         <= 1'b1;
        end else begin
            prev_pause_n <= pause_n_synchronised;

            if (pause_edge) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            state     <= state_n;
            k         <= k_n;
            seq_valid <= emit;
            if (emit) begin
                seq <= emit_seq;
            end
            // Derived from the next state so idle rises together with the
            // final Y pulse and falls the cycle after the start-of-frame edge.
            idle <= (state_n == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_pcd_seq_decoder.sv
// -----------------------------------------------------------------------------
// tb_pcd_seq_decoder
// Directed frames driven as pause waveforms; every seq_valid pulse is logged
// and compared with a hand-written expected sequence string.
// -----------------------------------------------------------------------------
module tb_pcd_seq_decoder;
    import ISO14443A_pkg::*;

    localparam int BT = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pause_n = 1'b1;
    PCDBitSequence seq;
    logic          seq_valid;
    logic          idle;

    pcd_seq_decoder #(
        .BIT_TICKS(BT),
        .TOL(16),
        .CNT_W(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pause_n_synchronised(pause_n),
        .seq(seq),
        .seq_valid(seq_valid),
        .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    int            cyc = 0;
    PCDBitSequence got_seq[$];
    logic          got_idle[$];
    logic          prev_valid = 1'b0;
    logic          prev_idle = 1'b1;
    int            idle_rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (seq_valid) begin
            got_seq.push_back(seq);
            got_idle.push_back(idle);
            check("single_cycle_valid", {31'd0, prev_valid}, 32'd0);
        end
        if (idle && !prev_idle) idle_rise_cyc <= cyc;
        prev_valid <= seq_valid;
        prev_idle  <= idle;
    end

    // ---------------------------------------------------------------- frames
    PCDBitSequence frame[$];
    PCDBitSequence exp_q[$];
    int            last_pause_cyc = 0;

    function automatic PCDBitSequence to_seq(input string c);
        case (c)
            "X":     return PCDBitSequence_X;
            "Z":     return PCDBitSequence_Z;
            "E":     return PCDBitSequence_ERROR;
            default: return PCDBitSequence_Y;
        endcase
    endfunction

    task automatic load(input string f, input string e);
        frame.delete();
        exp_q.delete();
        for (int i = 0; i < f.len(); i++) frame.push_back(to_seq(f.substr(i, i)));
        for (int i = 0; i < e.len(); i++) exp_q.push_back(to_seq(e.substr(i, i)));
    endtask

    // Z pauses start at the bit boundary, X pauses at mid-bit, Y has none.
    task automatic drive_frame(input int plen);
        int   pauses[$];
        logic low;
        foreach (frame[i]) begin
            if (frame[i] == PCDBitSequence_Z) pauses.push_back(i * BT);
            if (frame[i] == PCDBitSequence_X) pauses.push_back(i * BT + BT / 2);
        end
        for (int t = 0; t < frame.size() * BT; t++) begin
            @(negedge clk);
            low = 1'b0;
            foreach (pauses[j]) begin
                if (t >= pauses[j] && t < pauses[j] + plen) low = 1'b1;
                if (t == pauses[j]) last_pause_cyc = cyc;
            end
            pause_n = ~low;
        end
        @(negedge clk);
        pause_n = 1'b1;
    endtask

    task automatic run_frame(input string name, input int plen, input bit expect_err);
        int n;
        int m;
        got_seq.delete();
        got_idle.delete();
        drive_frame(plen);
        n = 0;
        while (!idle && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_end"}, {31'd0, idle}, 32'd1);
        repeat (300) @(negedge clk);   // nothing may follow the end of frame
        check({name, "_count"}, got_seq.size(), exp_q.size());
        m = (got_seq.size() < exp_q.size()) ? got_seq.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_seq%0d", name, i), 32'(got_seq[i]), 32'(exp_q[i]));
            if (!expect_err)
                check($sformatf("%s_idle%0d", name, i), {31'd0, got_idle[i]},
                      (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
        end
        if (expect_err)
            check({name, "_err_idle_gap"},
                  {31'd0, (idle_rise_cyc - last_pause_cyc) >= 2 * BT}, 32'd1);
    endtask

    task automatic reset_window(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check({name, "_idle"}, {31'd0, idle}, 32'd1);
            check({name, "_valid"}, {31'd0, seq_valid}, 32'd0);
            check({name, "_seq"}, 32'(seq), 32'(PCDBitSequence_Y));
        end
        rst_n = 1'b1;
    endtask

    function automatic string random_frame();
        string letters[3];
        string s;
        string prev;
        string c;
        letters = '{"X", "Y", "Z"};
        s    = "Z";
        prev = "Z";
        for (int i = 1; i < 8; i++) begin
            do begin
                c = letters[$urandom_range(0, 2)];
            end while ((prev == "X" && c == "Z") || (prev == "Y" && c == "Y") ||
                       (i == 7 && c == "Y"));
            s    = {s, c};
            prev = c;
        end
        return {s, "YY"};
    endfunction

    // ---------------------------------------------------------------- stimulus
    initial begin
        int plens[5];
        string rf;
        plens = '{28, 6, 14, 41, 50};

        repeat (3) @(negedge clk);
        check("reset_idle", {31'd0, idle}, 32'd1);
        check("reset_valid", {31'd0, seq_valid}, 32'd0);
        check("reset_seq", 32'(seq), 32'(PCDBitSequence_Y));
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        foreach (plens[i]) begin
            load("ZZXXYZYXYY", "ZZXXYZYXYY");
            run_frame($sformatf("frameA_p%0d", plens[i]), plens[i], 1'b0);
            load("ZYZYXYXYZYY", "ZYZYXYXYZYY");
            run_frame($sformatf("frameB_p%0d", plens[i]), plens[i], 1'b0);
        end

        load("ZXZZYY", "ZXE");
        run_frame("err_frame", 28, 1'b1);
        load("ZZXXYZYXYY", "ZZXXYZYXYY");
        run_frame("after_err", 28, 1'b0);

        for (int r = 0; r < 5; r++) begin
            rf = random_frame();
            load(rf, rf);
            run_frame($sformatf("rand%0d", r), 28, 1'b0);
        end

        // Reset in the middle of a frame, then in idle.
        load("ZZ", "");
        drive_frame(28);
        reset_window("rst_mid");
        got_seq.delete();
        repeat (400) @(negedge clk);
        check("rst_mid_no_emit", got_seq.size(), 32'd0);
        check("rst_mid_idle", {31'd0, idle}, 32'd1);
        load("ZYZYXYXYZYY", "ZYZYXYXYZYY");
        run_frame("after_rst_mid", 14, 1'b0);

        reset_window("rst_idle");
        repeat (10) @(negedge clk);
        load("ZZXXYZYXYY", "ZZXXYZYXYY");
        run_frame("after_rst_idle", 41, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pcd_seq_decoder.md
Name: pcd_seq_decoder

Overview:
- PICC receive-path block for ISO/IEC 14443A type A modified-Miller PCD→PICC frames. Sits after the pause_n synchroniser; clk is the 13.56 MHz carrier clock, so one bit period is 128 clocks.
- Classifies each bit period as sequence X (pause at mid-bit), Y (no pause) or Z (pause at bit start).
- Outputs one sequence per bit as a single-cycle valid pulse, flags X→Z and mistimed pauses as ERROR, and tracks frame idle.

Parameters:
- BIT_TICKS, 128, clocks per bit period (half bit = BIT_TICKS/2).
- TOL, 16, allowed ± deviation, in clocks, of a pause falling edge from its nominal time.
- CNT_W, 10, width of the tick counter; must hold 3*BIT_TICKS.

Ports:
- clk  in  1  carrier clock.
- rst_n  in  1  synchronous active-low reset.
- pause_n_synchronised  in  1  PCD pause, active low, already synchronised to clk.
- seq  out  PCDBitSequence (2)  last decoded sequence; held between pulses.
- seq_valid  out  1  one-cycle pulse when seq updates.
- idle  out  1  high when no frame is in progress.

Behaviour:
- Reset (rst_n low at posedge): idle=1, seq_valid=0, seq=PCDBitSequence_Y, state IDLE, counter=0, edge-detect register=1.
- Only pause falling edges are used: edge = prev_pause_n & ~pause_n_synchronised. This makes decoding independent of pause length (6–50 clocks).
- Counter c: cleared on the edge cycle, +1 per clock otherwise, saturating.
- All outputs are registered. seq/seq_valid appear the cycle after the decision cycle, and seq_valid is never high on two consecutive cycles.
- IDLE: first edge → emit Z (start of communication); idle=0; go to LAST_Z with k=0.
- Decoding state: last ∈ {LAST_Z, LAST_X}; k ∈ {0,1} = number of Y emitted since the last edge.
- Nominal next-bit start B = base + k*BIT_TICKS, where base=BIT_TICKS for LAST_Z and base=BIT_TICKS/2 for LAST_X.
- Edge with |c−B| ≤ TOL: if last=LAST_X and k=0 → emit ERROR (X→Z illegal); else emit Z, go to LAST_Z, k=0.
- Edge with |c−(B+BIT_TICKS/2)| ≤ TOL → emit X; go to LAST_X, k=0.
- Edge anywhere else → emit ERROR.
- No edge and c reaches B+BIT_TICKS/2+TOL+1:
  - k=0 → emit Y, k=1.
  - k=1 → emit Y and raise idle on the same cycle as that seq_valid (Y→Y end of communication); go to IDLE.
- ERROR: seq=ERROR pulse, then state ERR_WAIT with idle=0. Edges restart c. Go to IDLE (idle=1, no emission) once c reaches 2*BIT_TICKS with no edge. Any trailing frame traffic after an error is therefore discarded.
- Consequences: a frame never ends without a final Y emitted together with idle rising, except after ERROR. idle falls the cycle after the start-of-frame edge.
- Reset mid-frame: abandon the frame immediately; no emission.

Decomposition:
- ISO14443A_pkg holds typedef enum logic [1:0] PCDBitSequence {PCDBitSequence_X, PCDBitSequence_Y, PCDBitSequence_Z, PCDBitSequence_ERROR}.
- ISO14443A_pkg also holds the shared BIT_TICKS constant.
- No sub-module: edge detect, counter and FSM live in one file. The counter may later be split out as pause_interval_counter.

Test Plan:
- Frame Z,Z,X,X,Y,Z,Y,X,Y,Y with 28-clock pauses → exactly those 10 pulses in order. Last Y pulse coincides with idle rising. No pulse afterwards.
- Frame Z,Y,Z,Y,X,Y,X,Y,Z,Y,Y (all Y-in-the-middle combinations) → identical 11-pulse sequence; idle low throughout, high at the end.
- Repeat both frames with pause lengths 6, 14, 41 and 50 clocks → identical decoded output.
- Frame Z,X,Z,Z,Y,Y → pulses Z,X,ERROR only. idle rises ≥256 clocks after the last pause with no seq_valid. A following valid frame decodes normally.
- Random valid frames (10 sequences, no X→Z) → pulses match. seq_valid is always a single cycle.
- rst_n low for 5 cycles, mid-frame and idle → idle=1, seq_valid=0, seq=Y throughout reset. Next frame decodes from its SoC Z.
